stage_sequencer: RTL and testbench

Burn/stage sequencer for the Saturn V flight model: walks the four burns (S-IC, S-II, S-IVB first burn, S-IVB relight) and presents each burn's specific impulse, initial mass, propellant mass and burn time to the velocity integrator. It sits directly upstream of `getVelocity`: it drives that block's reset and parameter inputs and consumes its `ignition_end`. It emits stage-separation pulses for the telemetry printers and holds the parameters stable for the whole burn.

---
 rtl/stage_sequencer_if.sv | 30 +++
 rtl/stage_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_if.sv
// Bundle between the burn sequencer and the velocity integrator / telemetry side.
// The master side (the sequencer) drives the burn parameters and status flags.
interface stage_sequencer_if #(
  parameter int unsigned N = 64
);
  logic         start;
  logic         abort;
  logic         ignition_end;
  logic         engine_resetb;
  logic [N-1:0] specific_impulse;
  logic [N-1:0] initial_weight;
  logic [N-1:0] propellant_weight;
  logic [N-1:0] burntime;
  logic [2:0]   stage;
  logic         separation;
  logic         done;
  logic         aborted;

  modport master (
    input  start, abort, ignition_end,
    output engine_resetb, specific_impulse, initial_weight, propellant_weight,
           burntime, stage, separation, done, aborted
  );

  modport slave (
    output start, abort, ignition_end,
    input  engine_resetb, specific_impulse, initial_weight, propellant_weight,
           burntime, stage, separation, done, aborted
  );
endinterface

// File: rtl/stage_sequencer.sv
// Saturn V burn sequencer: steps through four burns, presents registered per-burn
// parameters to the velocity integrator and reports separation / done / abort.
module stage_sequencer #(
  parameter int unsigned N            = 64,
  parameter int unsigned ISP_1        = 263,
  parameter int unsigned ISP_2        = 421,
  parameter int unsigned ISP_3        = 421,
  parameter int unsigned PROP_1       = 2077000,
  parameter int unsigned PROP_2       = 456100,
  parameter int unsigned PROP_3       = 39136,
  parameter int unsigned PROP_4       = 83864,
  parameter int unsigned BURN_1       = 168,
  parameter int unsigned BURN_2       = 360,
  parameter int unsigned BURN_3       = 165,
  parameter int unsigned BURN_4       = 335,
  parameter int unsigned DRY_1        = 137000,
  parameter int unsigned DRY_2        = 40100,
  parameter int unsigned DRY_3        = 15200,
  parameter int unsigned PAYLOAD      = 27003,
  parameter int unsigned COAST_CYCLES = 100
) (
  input  logic               clk,
  input  logic               resetb,
  stage_sequencer_if.master  bus
);

  localparam int unsigned CW = (COAST_CYCLES > 1) ? $clog2(COAST_CYCLES) : 1;

  localparam logic [N-1:0] IW_1 = N'(PROP_1 + PROP_2 + PROP_3 + PROP_4
                                     + DRY_1 + DRY_2 + DRY_3 + PAYLOAD);
  localparam logic [N-1:0] IW_2 = IW_1 - N'(PROP_1 + DRY_1);
  localparam logic [N-1:0] IW_3 = N'(PROP_3 + PROP_4 + DRY_3 + PAYLOAD);
  localparam logic [N-1:0] IW_4 = N'(PROP_4 + DRY_3 + PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BURN,
    S_SEPARATE,
    S_COAST,
    S_DONE,
    S_ABORT
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     stage_q, stage_d;
  logic [N-1:0]   isp_q, isp_d;
  logic [N-1:0]   iw_q, iw_d;
  logic [N-1:0]   pw_q, pw_d;
  logic [N-1:0]   bt_q, bt_d;
  logic           eng_q, eng_d;
  logic           sep_q, sep_d;
  logic           done_q, done_d;
  logic           abrt_q, abrt_d;
  logic           first_q, first_d;
  logic [CW-1:0]  coast_q, coast_d;

  function automatic logic [N-1:0] isp_of(input logic [2:0] s);
    logic [N-1:0] r;
    case (s)
      3'd1:       r = N'(ISP_1);
      3'd2:       r = N'(ISP_2);
      3'd3, 3'd4: r = N'(ISP_3);
      default:    r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [N-1:0] iw_of(input logic [2:0] s);
    logic [N-1:0] r;
    case (s)
      3'd1:    r = IW_1;
      3'd2:    r = IW_2;
      3'd3:    r = IW_3;
      3'd4:    r = IW_4;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [N-1:0] pw_of(input logic [2:0] s);
    logic [N-1:0] r;
    case (s)
      3'd1:    r = N'(PROP_1);
      3'd2:    r = N'(PROP_2);
      3'd3:    r = N'(PROP_3);
      3'd4:    r = N'(PROP_4);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Never zero: the integrator divides by the burn time.
  function automatic logic [N-1:0] bt_of(input logic [2:0] s);
    logic [N-1:0] r;
    case (s)
      3'd1:    r = N'(BURN_1);
      3'd2:    r = N'(BURN_2);
      3'd3:    r = N'(BURN_3);
      3'd4:    r = N'(BURN_4);
      default: r = N'(1);
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    isp_d   = isp_q;
    iw_d    = iw_q;
    pw_d    = pw_q;
    bt_d    = bt_q;
    sep_d   = 1'b0;
    done_d  = done_q;
    abrt_d  = abrt_q;
    coast_d = coast_q;

    if (bus.abort && state_q != S_DONE && state_q != S_ABORT) begin
      state_d = S_ABORT;
      abrt_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_LOAD;
            stage_d = 3'd1;
          end
        end
        S_LOAD: state_d = S_BURN;
        S_BURN: begin
          // first_q blanks the integrator's stale ignition_end from the previous burn
          if (!first_q && bus.ignition_end) begin
            case (stage_q)
              3'd1, 3'd2: begin
                state_d = S_SEPARATE;
                sep_d   = 1'b1;
              end
              3'd3: begin
                state_d = S_COAST;
                coast_d = CW'(COAST_CYCLES - 1);
              end
              default: begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            endcase
          end
        end
        S_SEPARATE: begin
          state_d = S_LOAD;
          stage_d = stage_q + 3'd1;
        end
        S_COAST: begin
          if (coast_q == '0) begin
            state_d = S_LOAD;
            stage_d = 3'd4;
          end else begin
            coast_d = coast_q - 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (state_d == S_LOAD) begin
      isp_d = isp_of(stage_d);
      iw_d  = iw_of(stage_d);
      pw_d  = pw_of(stage_d);
      bt_d  = bt_of(stage_d);
    end

    eng_d   = !(state_d == S_IDLE || state_d == S_LOAD || state_d == S_ABORT);
    first_d = (state_d == S_BURN) && (state_q == S_LOAD);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      isp_q   <= '0;
      iw_q    <= '0;
      pw_q    <= '0;
      bt_q    <= N'(1);
      eng_q   <= 1'b0;
      sep_q   <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
      first_q <= 1'b0;
      coast_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      isp_q   <= isp_d;
      iw_q    <= iw_d;
      pw_q    <= pw_d;
      bt_q    <= bt_d;
      eng_q   <= eng_d;
      sep_q   <= sep_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
      first_q <= first_d;
      coast_q <= coast_d;
    end
  end

  assign bus.engine_resetb     = eng_q;
  assign bus.specific_impulse  = isp_q;
  assign bus.initial_weight    = iw_q;
  assign bus.propellant_weight = pw_q;
  assign bus.burntime          = bt_q;
  assign bus.stage             = stage_q;
  assign bus.separation        = sep_q;
  assign bus.done              = done_q;
  assign bus.aborted           = abrt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: stimulus queues cycle-tagged expected
// output snapshots, a negedge monitor compares them against the DUT.
module tb_stage_sequencer;

  logic clk = 1'b0;
  logic resetb;
  always #5 clk = ~clk;

  stage_sequencer_if #(.N(64)) bus();

  stage_sequencer #(.N(64), .COAST_CYCLES(4)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  typedef struct {
    logic [63:0] isp, iw, pw, bt;
  } prm_t;

  typedef struct {
    int          cyc;
    string       name;
    logic        eng;
    logic [2:0]  stage;
    logic        sep, dn, ab;
    prm_t        p;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   tests   = 0;
  int   fails   = 0;
  int   sep_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed burn parameters (initial mass = remaining stack at ignition).
  function automatic prm_t prm(input int b);
    prm_t r;
    case (b)
      1:       begin r.isp = 263; r.iw = 2875403; r.pw = 2077000; r.bt = 168; end
      2:       begin r.isp = 421; r.iw = 661403;  r.pw = 456100;  r.bt = 360; end
      3:       begin r.isp = 421; r.iw = 165203;  r.pw = 39136;   r.bt = 165; end
      4:       begin r.isp = 421; r.iw = 126067;  r.pw = 83864;   r.bt = 335; end
      default: begin r.isp = 0;   r.iw = 0;       r.pw = 0;       r.bt = 1;   end
    endcase
    return r;
  endfunction

  task automatic push(input int c, input string nm, input logic eng, input logic [2:0] st,
                      input logic sep, input logic dn, input logic ab, input prm_t p);
    exp_t e;
    e.cyc = c; e.name = nm; e.eng = eng; e.stage = st;
    e.sep = sep; e.dn = dn; e.ab = ab; e.p = p;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [262:0] act, want;
    if (bus.separation === 1'b1) sep_cnt++;
    act = {bus.engine_resetb, bus.stage, bus.separation, bus.done, bus.aborted,
           bus.specific_impulse, bus.initial_weight, bus.propellant_weight, bus.burntime};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        want = {sb[i].eng, sb[i].stage, sb[i].sep, sb[i].dn, sb[i].ab,
                sb[i].p.isp, sb[i].p.iw, sb[i].p.pw, sb[i].p.bt};
        tests++;
        if (act !== want) begin
          fails++;
          $display("FAIL %s @cyc %0d: got eng=%b stage=%0d sep=%b done=%b ab=%b isp=%0d iw=%0d pw=%0d bt=%0d, want eng=%b stage=%0d sep=%b done=%b ab=%b isp=%0d iw=%0d pw=%0d bt=%0d",
                   sb[i].name, cyc, bus.engine_resetb, bus.stage, bus.separation, bus.done,
                   bus.aborted, bus.specific_impulse, bus.initial_weight, bus.propellant_weight,
                   bus.burntime, sb[i].eng, sb[i].stage, sb[i].sep, sb[i].dn, sb[i].ab,
                   sb[i].p.isp, sb[i].p.iw, sb[i].p.pw, sb[i].p.bt);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL %s: expectation for cyc %0d expired at cyc %0d", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
  end

  // Ends burn s (1 or 2) and expects SEPARATE, LOAD of s+1, then BURN.
  task automatic end_burn(input int s);
    int c;
    c = cyc;
    bus.ignition_end = 1'b1;
    push(c + 1, "separate",   1'b1, 3'(s),     1'b1, 1'b0, 1'b0, prm(s));
    push(c + 2, "load_next",  1'b0, 3'(s + 1), 1'b0, 1'b0, 1'b0, prm(s + 1));
    push(c + 3, "burn_next",  1'b1, 3'(s + 1), 1'b0, 1'b0, 1'b0, prm(s + 1));
    tick(1);
    bus.ignition_end = 1'b0;
    tick(4);
  endtask

  initial begin
    int c;
    resetb           = 1'b0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.ignition_end = 1'b0;
    tick(3);
    resetb = 1'b1;

    for (int k = 1; k <= 20; k++)
      push(cyc + k, "idle_no_start", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, prm(0));
    tick(20);

    // Launch with ignition_end held high through LOAD and the blanked BURN cycle.
    c = cyc;
    bus.start        = 1'b1;
    bus.ignition_end = 1'b1;
    push(c + 1, "load1",       1'b0, 3'd1, 1'b0, 1'b0, 1'b0, prm(1));
    push(c + 2, "burn1_blank", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, prm(1));
    push(c + 3, "burn1_stale", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, prm(1));
    push(c + 4, "burn1_hold",  1'b1, 3'd1, 1'b0, 1'b0, 1'b0, prm(1));
    tick(1);
    bus.start = 1'b0;
    tick(2);
    bus.ignition_end = 1'b0;
    tick(3);

    end_burn(1);
    end_burn(2);

    // Burn 3 end: four coast cycles without separation, then LOAD of burn 4.
    c = cyc;
    bus.ignition_end = 1'b1;
    for (int k = 1; k <= 4; k++)
      push(c + k, "coast", 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, prm(3));
    push(c + 5, "load4", 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, prm(4));
    push(c + 6, "burn4", 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, prm(4));
    tick(1);
    bus.ignition_end = 1'b0;
    tick(7);

    // Burn 4 end: DONE is sticky and ignores a late start.
    c = cyc;
    bus.ignition_end = 1'b1;
    push(c + 1, "done", 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, prm(4));
    for (int k = 2; k <= 4; k++)
      push(c + k, "done_sticky", 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, prm(4));
    tick(1);
    bus.ignition_end = 1'b0;
    bus.start        = 1'b1;
    tick(4);
    bus.start = 1'b0;

    tests++;
    if (sep_cnt != 2) begin
      fails++;
      $display("FAIL sep_pulse_count: got %0d, want 2", sep_cnt);
    end

    // Asynchronous reset clears outputs within the same cycle.
    resetb = 1'b0;
    push(cyc,     "async_reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, prm(0));
    push(cyc + 1, "reset_held",  1'b0, 3'd0, 1'b0, 1'b0, 1'b0, prm(0));
    tick(2);
    resetb = 1'b1;
    for (int k = 1; k <= 3; k++)
      push(cyc + k, "idle_after_reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, prm(0));
    tick(4);

    c = cyc;
    bus.start = 1'b1;
    push(c + 1, "load1_rerun", 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, prm(1));
    tick(1);
    bus.start = 1'b0;
    tick(4);
    end_burn(1);

    // abort coincident with ignition_end in burn 2: no separation, engine held in reset.
    c = cyc;
    bus.abort        = 1'b1;
    bus.ignition_end = 1'b1;
    push(c + 1, "abort", 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, prm(2));
    for (int k = 2; k <= 4; k++)
      push(c + k, "abort_sticky", 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, prm(2));
    tick(1);
    bus.abort        = 1'b0;
    bus.ignition_end = 1'b0;
    tick(4);

    resetb = 1'b0;
    tick(1);
    resetb = 1'b1;
    for (int k = 1; k <= 3; k++)
      push(cyc + k, "idle_after_abort_reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, prm(0));
    tick(4);

    for (int k = 0; k < 10 && sb.size() > 0; k++) tick(1);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
